// File: rtl/adc_scheduler.sv
// Channel sequencer for the shared SPI ADC capture block.
// Round-robin over ch_mask with one-shot priority requests and a watchdog.
module adc_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      cap_ready,
  input  logic [DATA_W-1:0]         cap_data,
  output logic                      cap_en,
  output logic [$clog2(NUM_CH)-1:0] cap_address,
  output logic                      cap_ack,
  output logic                      sample_valid,
  output logic [$clog2(NUM_CH)-1:0] sample_ch,
  output logic [DATA_W-1:0]         sample_data,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clear
);

  localparam int AW = $clog2(NUM_CH);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_WAIT,
    S_ACK,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [AW-1:0]     ptr;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_clr;
  logic [SW-1:0]     settle_cnt;
  logic [TW-1:0]     tmo_cnt;

  logic              hit_pend;
  logic              hit_mask;
  logic [AW-1:0]     win_pend;
  logic [AW-1:0]     win_mask;
  logic [AW-1:0]     idx;
  logic              sel_hit;
  logic [AW-1:0]     sel_ch;
  logic              settle_done;
  logic              tmo_last;
  logic              done;

  // Walk from ptr+NUM_CH down to ptr+1 so the nearest hit is written last.
  always_comb begin
    hit_pend = 1'b0;
    hit_mask = 1'b0;
    win_pend = '0;
    win_mask = '0;
    idx      = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr + AW'(i);
      if (pend[idx]) begin
        hit_pend = 1'b1;
        win_pend = idx;
      end
      if (ch_mask[idx]) begin
        hit_mask = 1'b1;
        win_mask = idx;
      end
    end
  end

  assign sel_hit     = hit_pend | hit_mask;
  assign sel_ch      = hit_pend ? win_pend : win_mask;
  assign settle_done = (settle_cnt == '0);
  assign tmo_last    = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign done        = (state == S_ACK) || (state == S_ABORT);
  assign pend_clr    = done ? (NUM_CH'(1) << cap_address) : '0;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (enable && ((pend | req | ch_mask) != '0))
          state_n = S_SELECT;
      end
      S_SELECT: begin
        if (!enable || !sel_hit) state_n = S_IDLE;
        else                     state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (!enable)          state_n = S_IDLE;
        else if (settle_done) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)        state_n = S_IDLE;
        else if (cap_ready) state_n = S_ACK;
        else if (tmo_last)  state_n = S_ABORT;
      end
      S_ACK:   state_n = S_DRAIN;
      S_DRAIN: begin
        if (!cap_ready)
          state_n = enable ? S_SELECT : S_IDLE;
      end
      S_ABORT: state_n = S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end

  assign cap_en       = (state == S_WAIT) || (state == S_ACK);
  assign cap_ack      = (state == S_ACK);
  assign sample_valid = (state == S_ACK);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ptr         <= AW'(NUM_CH - 1);
      pend        <= '0;
      cap_address <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      sample_ch   <= '0;
      sample_data <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      // A request landing on the clearing cycle must survive.
      pend  <= (pend & ~pend_clr) | req;
      if (state == S_SELECT && enable && sel_hit) begin
        cap_address <= sel_ch;
        ptr         <= sel_ch;
        settle_cnt  <= SW'(SETTLE_CYC - 1);
      end else if (state == S_SETTLE && !settle_done) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (state != S_WAIT)
        tmo_cnt <= '0;
      else if (tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT && enable && cap_ready) begin
        sample_data <= cap_data;
        sample_ch   <= cap_address;
      end
      if (state == S_ABORT)
        timeout_err <= 1'b1;
      else if (err_clear)
        timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scheduler.sv
// Bench for adc_scheduler: capture-block model plus a
// transaction-level scheduling model predicting each channel.
module tb_adc_scheduler;

  localparam int NCH = 8;
  localparam int SET = 4;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [7:0]  req = '0;
  logic        cap_ready = 1'b0;
  logic [11:0] cap_data = '0;
  logic        err_clear = 1'b0;
  logic        cap_en;
  logic [2:0]  cap_address;
  logic        cap_ack;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic [11:0] sample_data;
  logic        busy;
  logic        timeout_err;

  adc_scheduler #(
    .NUM_CH(NCH), .DATA_W(12),
    .SETTLE_CYC(SET), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ch_mask(ch_mask), .req(req),
    .cap_ready(cap_ready), .cap_data(cap_data),
    .cap_en(cap_en), .cap_address(cap_address),
    .cap_ack(cap_ack), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data),
    .busy(busy), .timeout_err(timeout_err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         sv_count = 0;
  logic [7:0] m_pend = '0;
  int         m_ptr = NCH - 1;

  always @(negedge clk) if (sample_valid) sv_count++;

  // Next channel: nearest pending request after the last one served,
  // otherwise the nearest masked channel; -1 when nothing qualifies.
  function automatic int pick(input logic [7:0] p,
                              input logic [7:0] m,
                              input int last);
    for (int i = 1; i <= NCH; i++)
      if (p[(last + i) % NCH]) return (last + i) % NCH;
    for (int i = 1; i <= NCH; i++)
      if (m[(last + i) % NCH]) return (last + i) % NCH;
    return -1;
  endfunction

  task automatic wait_start(output bit ok);
    int         stable;
    int         exp;
    logic [2:0] prev;
    stable = 0;
    prev = cap_address;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk); #1;
      if (cap_en) ok = 1'b1;
      else if (cap_address == prev) stable++;
      else begin
        stable = 1;
        prev = cap_address;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL start: cap_en got 0 want 1 within 300 cycles");
      return;
    end
    exp = pick(m_pend, ch_mask, m_ptr);
    total++;
    if (stable < SET) begin
      bad++;
      $display("FAIL settle: stable got %0d want >=%0d", stable, SET);
    end
    total++;
    if (exp < 0 || cap_address !== exp[2:0]) begin
      bad++;
      $display("FAIL channel: got %0d want %0d", cap_address, exp);
    end
    m_ptr = (exp >= 0) ? exp : int'(cap_address);
  endtask

  task automatic do_conv(input int dly, input int hold,
                         input logic [7:0] rq, input logic [7:0] nmask,
                         input logic [7:0] ack_rq, input bit rnd);
    bit          ok;
    int          ch;
    int          sv0;
    logic [11:0] d;
    wait_start(ok);
    if (!ok) return;
    ch = int'(cap_address);
    req = rq;
    m_pend |= rq;
    @(posedge clk); #1;
    req = '0;
    ch_mask = nmask;
    repeat (dly - 1) begin @(posedge clk); #1; end
    d = rnd ? 12'($urandom) : 12'(12'h100 + ch);
    cap_data = d;
    cap_ready = 1'b1;
    sv0 = sv_count;
    @(posedge clk); #1;
    total++;
    if (sample_valid !== 1'b1 || cap_ack !== 1'b1) begin
      bad++;
      $display("FAIL latency: valid/ack got %b%b want 11",
               sample_valid, cap_ack);
    end
    total++;
    if (sample_ch !== ch[2:0] || sample_data !== d) begin
      bad++;
      $display("FAIL sample: got ch%0d %h want ch%0d %h",
               sample_ch, sample_data, ch, d);
    end
    m_pend[ch] = 1'b0;
    m_pend |= ack_rq;
    req = ack_rq;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      req = '0;
      total++;
      if (cap_ack !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold: ack/valid/busy got %b%b%b want 001",
                 cap_ack, sample_valid, busy);
      end
    end
    cap_ready = 1'b0;
    if (req != '0) begin @(posedge clk); #1; req = '0; end
    @(posedge clk); #1;
    total++;
    if (sv_count - sv0 != 1) begin
      bad++;
      $display("FAIL count: samples got %0d want 1", sv_count - sv0);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({cap_en, cap_ack, sample_valid, busy, timeout_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {cap_en, cap_ack, sample_valid, busy, timeout_err});
    end
    total++;
    if ({cap_address, sample_ch, sample_data} !== 18'b0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0",
               {cap_address, sample_ch, sample_data});
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    ch_mask = 8'h05;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) do_conv(20, 0, '0, 8'h05, '0, 1'b0);
    do_conv(20, 0, '0, 8'h01, '0, 1'b0);
  endtask

  task automatic test_priority();
    do_conv(10, 0, 8'h20, 8'h01, '0, 1'b0);
    do_conv(10, 0, '0, 8'h01, 8'h20, 1'b0);
    do_conv(10, 0, '0, 8'h01, '0, 1'b0);
    do_conv(10, 0, '0, 8'h06, '0, 1'b0);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    int ch;
    int sv0;
    sv0 = sv_count;
    wait_start(ok);
    if (!ok) return;
    ch = int'(cap_address);
    n = 1;
    while (cap_en && n < 200) begin
      @(posedge clk); #1;
      if (cap_en) n++;
    end
    total++;
    if (n != TMO) begin
      bad++;
      $display("FAIL tmo_len: cap_en cycles got %0d want %0d", n, TMO);
    end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_set: timeout_err got %b want 1", timeout_err);
    end
    total++;
    if (sv_count != sv0) begin
      bad++;
      $display("FAIL tmo_sample: got %0d want 0", sv_count - sv0);
    end
    m_pend[ch] = 1'b0;
    do_conv(5, 0, '0, 8'h06, '0, 1'b1);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: timeout_err got %b want 1", timeout_err);
    end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: timeout_err got %b want 0", timeout_err);
    end
  endtask

  task automatic test_hold();
    do_conv(8, 10, '0, 8'h06, '0, 1'b1);
  endtask

  task automatic test_enable();
    bit ok;
    int sv0;
    ch_mask = '0;
    req = 8'h08;
    m_pend |= 8'h08;
    @(posedge clk); #1;
    req = '0;
    wait_start(ok);
    if (!ok) return;
    repeat (3) begin @(posedge clk); #1; end
    enable = 1'b0;
    sv0 = sv_count;
    @(posedge clk); #1;
    total++;
    if (cap_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL en_off: cap_en/busy got %b%b want 00", cap_en, busy);
    end
    repeat (10) begin @(posedge clk); #1; end
    total++;
    if (sv_count != sv0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL en_idle: samples %0d busy %b want 0 0",
               sv_count - sv0, busy);
    end
    enable = 1'b1;
    do_conv(6, 0, '0, '0, '0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL en_done: busy got %b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    ch_mask = 8'hFF;
    wait_start(ok);
    if (!ok) return;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    total++;
    if ({cap_en, cap_ack, sample_valid, busy, cap_address} !== 7'b0) begin
      bad++;
      $display("FAIL async_rst: got %b want 0",
               {cap_en, cap_ack, sample_valid, busy, cap_address});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_pend = '0;
    m_ptr = NCH - 1;
    do_conv(4, 0, '0, 8'hFF, '0, 1'b1);
  endtask

  task automatic test_random();
    int         dly;
    int         hold;
    logic [7:0] rq;
    logic [7:0] nm;
    logic [7:0] arq;
    for (int i = 0; i < 30; i++) begin
      dly = $urandom_range(1, 30);
      hold = $urandom_range(0, 3);
      rq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      arq = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
      nm = ch_mask;
      if ($urandom_range(0, 3) == 0) begin
        nm = 8'($urandom);
        if (nm == 8'h00) nm = 8'h81;
      end
      do_conv(dly, hold, rq, nm, arq, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_timeout();
    test_hold();
    test_enable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
